// File: rtl/simon_round_engine_if.sv
// Bus between the key-schedule generator / block I/O side and the Simon round engine.
// The master drives keys and block requests; the engine (slave) returns status and results.
interface simon_round_engine_if #(
  parameter int WORD = 64
);
  logic              key_wr_en;
  logic [6:0]        key_rnd;
  logic [WORD-1:0]   key_sched;
  logic              key_done;
  logic              start;
  logic              decrypt;
  logic [2*WORD-1:0] block_in;
  logic              keys_ready;
  logic              busy;
  logic              valid_out;
  logic [2*WORD-1:0] block_out;

  modport master (
    output key_wr_en, key_rnd, key_sched, key_done, start, decrypt, block_in,
    input  keys_ready, busy, valid_out, block_out
  );

  modport slave (
    input  key_wr_en, key_rnd, key_sched, key_done, start, decrypt, block_in,
    output keys_ready, busy, valid_out, block_out
  );
endinterface

// File: rtl/simon_round_engine.sv
// Simon 128/256 iterative round engine: one round per clock, round keys taken from
// an internal key store that the key-schedule generator fills before use.
module simon_round_engine #(
  parameter int ROUNDS = 72,
  parameter int WORD   = 64
) (
  input logic                 clk,
  input logic                 res,
  simon_round_engine_if.slave bus
);
  localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [WORD-1:0]   r_mem [ROUNDS];
  logic [WORD-1:0]   r_key;
  logic [WORD-1:0]   r_x;
  logic [WORD-1:0]   r_y;
  logic [WORD-1:0]   w_x_nxt;
  logic [WORD-1:0]   w_y_nxt;
  logic [6:0]        r_cnt;
  logic [6:0]        r_addr;
  logic [6:0]        w_rd_addr;
  logic              r_dec;
  logic              r_busy;
  logic              r_valid;
  logic              r_keys_ready;
  logic [2*WORD-1:0] r_block_out;
  logic              w_accept;
  logic              w_key_wr;

  function automatic logic [WORD-1:0] simon_f(input logic [WORD-1:0] v);
    logic [WORD-1:0] v1;
    logic [WORD-1:0] v2;
    logic [WORD-1:0] v8;
    v1 = {v[WORD-2:0], v[WORD-1]};
    v2 = {v[WORD-3:0], v[WORD-1:WORD-2]};
    v8 = {v[WORD-9:0], v[WORD-1:WORD-8]};
    simon_f = (v1 & v8) ^ v2;
  endfunction

  assign w_accept = (r_state == IDLE) && bus.start && r_keys_ready;
  assign w_key_wr = bus.key_wr_en && (bus.key_rnd < 7'(ROUNDS)) && !r_busy;

  // In IDLE the first key is fetched speculatively so round 0 has it on the first RUN edge.
  always_comb begin
    w_rd_addr = r_addr;
    if (r_state == IDLE) begin
      w_rd_addr = bus.decrypt ? LAST_RND : 7'd0;
    end else begin
      w_rd_addr = r_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_key_wr) begin
      r_mem[bus.key_rnd] <= bus.key_sched;
    end
    if (w_rd_addr < 7'(ROUNDS)) begin
      r_key <= r_mem[w_rd_addr];
    end else begin
      r_key <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_keys_ready <= 1'b0;
    end else if (w_key_wr) begin
      r_keys_ready <= 1'b0;
    end else if (bus.key_done && !bus.key_wr_en) begin
      r_keys_ready <= 1'b1;
    end else begin
      r_keys_ready <= r_keys_ready;
    end
  end

  always_comb begin
    if (r_dec) begin
      w_x_nxt = r_y;
      w_y_nxt = r_x ^ simon_f(r_y) ^ r_key;
    end else begin
      w_x_nxt = r_y ^ simon_f(r_x) ^ r_key;
      w_y_nxt = r_x;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = w_accept ? RUN : IDLE;
      RUN:     w_next_state = (r_cnt == LAST_RND) ? DONE : RUN;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs, sequenced by the current state.
  always_ff @(posedge clk) begin
    if (res) begin
      r_x         <= '0;
      r_y         <= '0;
      r_cnt       <= 7'd0;
      r_addr      <= 7'd0;
      r_dec       <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_block_out <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x    <= bus.block_in[2*WORD-1:WORD];
            r_y    <= bus.block_in[WORD-1:0];
            r_dec  <= bus.decrypt;
            r_cnt  <= 7'd0;
            r_addr <= bus.decrypt ? (LAST_RND - 7'd1) : 7'd1;
            r_busy <= 1'b1;
          end
        end
        RUN: begin
          r_x    <= w_x_nxt;
          r_y    <= w_y_nxt;
          r_cnt  <= r_cnt + 7'd1;
          r_addr <= r_dec ? (r_addr - 7'd1) : (r_addr + 7'd1);
        end
        DONE: begin
          r_block_out <= {r_x, r_y};
          r_valid     <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign bus.keys_ready = r_keys_ready;
  assign bus.busy       = r_busy;
  assign bus.valid_out  = r_valid;
  assign bus.block_out  = r_block_out;
endmodule

// File: tb/tb_simon_round_engine.sv
// Directed bench for simon_round_engine: golden Simon 128/256 vectors, readiness gating,
// busy protection, mid-run reset and back-to-back throughput.
module tb_simon_round_engine;
  localparam logic [127:0] PT = 128'h74206e69206d6f6f_6d69732061207369;
  localparam logic [127:0] CT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

  logic        clk = 1'b0;
  logic        res;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [63:0] ks [72];

  simon_round_engine_if #(.WORD(64)) bus ();
  simon_round_engine #(.ROUNDS(72), .WORD(64)) dut (.clk(clk), .res(res), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Simon 128/256 key expansion (m = 4, z4 constant sequence).
  task automatic build_ks();
    logic [63:0] z;
    logic [63:0] tmp;
    z = 64'h3dc94c3a046d678b;
    ks[0] = 64'h0706050403020100;
    ks[1] = 64'h0f0e0d0c0b0a0908;
    ks[2] = 64'h1716151413121110;
    ks[3] = 64'h1f1e1d1c1b1a1918;
    for (int i = 4; i < 72; i++) begin
      tmp   = ror64(ks[i-1], 3) ^ ks[i-3];
      tmp   = tmp ^ ror64(tmp, 1);
      ks[i] = 64'hffff_ffff_ffff_fffc ^ {63'd0, z[(i-4)%62]} ^ ks[i-4] ^ tmp;
    end
  endtask

  task automatic load_keys();
    for (int r = 0; r < 72; r++) begin
      bus.key_wr_en = 1'b1;
      bus.key_rnd   = 7'(r);
      bus.key_sched = ks[r];
      tick();
    end
    bus.key_wr_en = 1'b0;
    bus.key_done  = 1'b1;
    tick();
    bus.key_done  = 1'b0;
  endtask

  // Request at the next edge, then scramble the inputs to show they are sampled only once.
  task automatic go(input logic dec, input logic [127:0] blk);
    bus.start    = 1'b1;
    bus.decrypt  = dec;
    bus.block_in = blk;
    tick();
    bus.start    = 1'b0;
    bus.decrypt  = ~dec;
    bus.block_in = ~blk;
  endtask

  task automatic wait_valid(input int inject_at, output int lat, output logic b1,
                            output logic bv, output logic [127:0] blk);
    lat = -1;
    b1  = 1'b0;
    bv  = 1'b1;
    blk = '0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == 1) b1 = bus.busy;
      if (n == inject_at) begin
        bus.start     = 1'b1;
        bus.key_wr_en = 1'b1;
        bus.key_rnd   = 7'd5;
        bus.key_sched = '1;
      end else begin
        bus.start     = 1'b0;
        bus.key_wr_en = 1'b0;
      end
      if (bus.valid_out === 1'b1) begin
        lat = n;
        bv  = bus.busy;
        blk = bus.block_out;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    int          lat2;
    int          c1;
    int          nvalid;
    logic        b1;
    logic        bv;
    logic [127:0] blk;
    logic [127:0] blk2;

    res           = 1'b1;
    bus.key_wr_en = 1'b0;
    bus.key_rnd   = 7'd0;
    bus.key_sched = 64'd0;
    bus.key_done  = 1'b0;
    bus.start     = 1'b0;
    bus.decrypt   = 1'b0;
    bus.block_in  = 128'd0;
    build_ks();
    tick();
    tick();
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_valid", 128'(bus.valid_out), 128'd0);
    chk("rst_block", bus.block_out, 128'd0);
    chk("rst_keys_ready", 128'(bus.keys_ready), 128'd0);
    res = 1'b0;
    tick();

    // Start without a schedule loaded must be ignored.
    go(1'b0, PT);
    wait_valid(0, lat, b1, bv, blk);
    chk("gate_no_busy", 128'(b1), 128'd0);
    chk("gate_no_valid", 128'(lat), 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff);

    load_keys();
    chk("keys_ready_set", 128'(bus.keys_ready), 128'd1);

    bus.key_wr_en = 1'b1;
    bus.key_rnd   = 7'd72;
    bus.key_sched = '1;
    tick();
    bus.key_wr_en = 1'b0;
    tick();
    chk("rnd72_keys_ready", 128'(bus.keys_ready), 128'd1);

    go(1'b0, PT);
    wait_valid(0, lat, b1, bv, blk);
    chk("enc_block", blk, CT);
    chk("enc_latency", 128'(lat), 128'd73);
    chk("enc_busy_early", 128'(b1), 128'd1);
    chk("enc_busy_at_valid", 128'(bv), 128'd0);

    tick();
    go(1'b1, CT);
    wait_valid(0, lat, b1, bv, blk);
    chk("dec_block", blk, PT);
    chk("dec_latency", 128'(lat), 128'd73);
    tick();
    chk("valid_one_cycle", 128'(bus.valid_out), 128'd0);
    chk("block_held", bus.block_out, PT);

    // Start plus key write mid-run must both be dropped.
    go(1'b0, PT);
    wait_valid(30, lat, b1, bv, blk);
    chk("prot_block", blk, CT);
    chk("prot_latency", 128'(lat), 128'd73);
    chk("prot_keys_ready", 128'(bus.keys_ready), 128'd1);
    tick();
    tick();
    chk("prot_no_restart", 128'(bus.busy), 128'd0);

    go(1'b0, PT);
    wait_valid(0, lat, b1, bv, blk);
    c1 = cyc;
    go(1'b0, PT);
    wait_valid(0, lat2, b1, bv, blk2);
    chk("b2b_first", blk, CT);
    chk("b2b_second", blk2, CT);
    chk("b2b_gap", 128'(cyc - c1), 128'd74);

    tick();
    go(1'b0, PT);
    repeat (39) tick();
    chk("mid_run_busy", 128'(bus.busy), 128'd1);
    res = 1'b1;
    tick();
    chk("mrst_busy", 128'(bus.busy), 128'd0);
    chk("mrst_valid", 128'(bus.valid_out), 128'd0);
    chk("mrst_block", bus.block_out, 128'd0);
    chk("mrst_keys_ready", 128'(bus.keys_ready), 128'd0);
    res = 1'b0;
    nvalid = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (bus.valid_out === 1'b1) nvalid++;
    end
    chk("mrst_no_valid", 128'(nvalid), 128'd0);
    go(1'b0, PT);
    tick();
    chk("mrst_start_ignored", 128'(bus.busy), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
